uart_rx_fifo_writer: RTL and testbench

Serial UART receiver that fills the 10-bit receive FIFO on its write side; the register block drains the other side.
- Deserialises 8N1/8E1/8O1 frames from rxd using 16x oversampling ticks from the baud generator.
- Pushes one 10-bit word per frame: {parity_err, frame_err, data[7:0]}.
- Flags overrun when the FIFO is full at push time.

---
 rtl/uart_rx_fifo_writer.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_fifo_writer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_writer.sv
// UART receiver (8N1/8E1/8O1, oversampled) that writes one 10-bit word per frame
// into a receive FIFO: {parity_err, frame_err, data[7:0]}, with sticky overrun.
module uart_rx_fifo_writer #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       aclr,
    input  logic       baud_tick16,
    input  logic       rxd,
    input  logic       parity_en,
    input  logic       parity_odd,
    output logic [9:0] fifo_data,
    output logic       fifo_wrreq,
    input  logic       fifo_full,
    output logic       overrun,
    input  logic       clr_overrun,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    rxs;
    logic                    rxs_prev_q;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [2:0]              bit_q, bit_d;
    logic [7:0]              shreg_q, shreg_d;
    logic                    par_en_q, par_en_d;
    logic                    par_odd_q, par_odd_d;
    logic                    par_err_q, par_err_d;
    logic [9:0]              data_q, data_d;
    logic                    wrreq_q, wrreq_d;
    logic                    overrun_q, overrun_d;
    logic                    set_ovr;
    logic                    tick_mid;
    logic                    tick_last;

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign tick_mid  = (cnt_q == CntW'(OVERSAMPLE / 2 - 1));
    assign tick_last = (cnt_q == CntW'(OVERSAMPLE - 1));

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            sync_q     <= '1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd};
            rxs_prev_q <= rxs;
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            wrreq_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            wrreq_q   <= wrreq_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        par_err_d = par_err_q;
        data_d    = data_q;
        wrreq_d   = 1'b0;
        set_ovr   = 1'b0;

        case (state_q)
            StIdle: begin
                if (rxs_prev_q && !rxs) begin
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_tick16) begin
                    if (tick_mid) begin
                        if (!rxs) begin
                            cnt_d     = '0;
                            bit_d     = '0;
                            par_en_d  = parity_en;
                            par_odd_d = parity_odd;
                            par_err_d = 1'b0;
                            state_d   = StData;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (baud_tick16) begin
                    cnt_d = cnt_q + 1'b1;
                    if (tick_last) begin
                        shreg_d = {rxs, shreg_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = par_en_q ? StParity : StStop;
                        end
                    end
                end
            end
            StParity: begin
                if (baud_tick16) begin
                    cnt_d = cnt_q + 1'b1;
                    if (tick_last) begin
                        par_err_d = ((^shreg_q) ^ rxs) != par_odd_q;
                        state_d   = StStop;
                    end
                end
            end
            StStop: begin
                if (baud_tick16) begin
                    cnt_d = cnt_q + 1'b1;
                    if (tick_last) begin
                        if (!fifo_full) begin
                            wrreq_d = 1'b1;
                            data_d  = {par_err_q, ~rxs, shreg_q};
                        end else begin
                            set_ovr = 1'b1;
                        end
                        // A low stop sample is a break: park until the line recovers.
                        state_d = rxs ? StIdle : StBrkWait;
                    end
                end
            end
            StBrkWait: begin
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        overrun_d = set_ovr | (overrun_q & ~clr_overrun);
    end

    assign fifo_data  = data_q;
    assign fifo_wrreq = wrreq_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q == StStart) || (state_q == StData) ||
                        (state_q == StParity) || (state_q == StStop);

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Randomised self-checking bench: frames are built bit by bit on rxd and the
// expected FIFO words are computed from the frame contents.
module tb_uart_rx_fifo_writer;

    logic       clock = 1'b0;
    logic       aclr = 1'b1;
    logic       baud_tick16 = 1'b0;
    logic       rxd = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic [9:0] fifo_data;
    logic       fifo_wrreq;
    logic       fifo_full = 1'b0;
    logic       overrun;
    logic       clr_overrun = 1'b0;
    logic       busy;

    int         n_total = 0;
    int         n_bad = 0;
    int         div = 0;
    logic [9:0] got_q[$];
    logic       seen_set_clr = 1'b0;

    uart_rx_fifo_writer #(
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .clock      (clock),
        .aclr       (aclr),
        .baud_tick16(baud_tick16),
        .rxd        (rxd),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .fifo_data  (fifo_data),
        .fifo_wrreq (fifo_wrreq),
        .fifo_full  (fifo_full),
        .overrun    (overrun),
        .clr_overrun(clr_overrun),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // One oversample tick every 4 clocks.
    always @(negedge clock) begin
        div = div + 1;
        baud_tick16 = (div % 4 == 0);
    end

    always @(negedge clock) begin
        if (fifo_wrreq) got_q.push_back(fifo_data);
        if (overrun && clr_overrun) seen_set_clr = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int k);
        int n = 0;
        while (n < k) begin
            @(posedge clock);
            if (baud_tick16) n++;
        end
    endtask

    // Drive one bit period; returns 1ns after the tick edge ending it.
    task automatic send_bit(input logic b);
        rxd = b;
        wait_ticks(16);
        #1;
    endtask

    function automatic logic [9:0] model_word(input logic [7:0] d, input logic pe,
                                              input logic po, input logic pbit,
                                              input logic stop);
        int ones;
        logic perr;
        ones = $countones(d) + int'(pbit);
        perr = pe && ((ones % 2) != int'(po));
        return {perr, ~stop, d};
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic po,
                              input logic pbit, input logic stop, input logic flip);
        parity_en  = pe;
        parity_odd = po;
        send_bit(1'b0);
        check_eq("busy_in_frame", busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            if (i == 0 && flip) begin
                parity_en  = 1'($urandom);
                parity_odd = 1'($urandom);
            end
        end
        if (pe) send_bit(pbit);
        send_bit(stop);
        if (!stop) send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic expect_one(input string tag, input logic [9:0] exp);
        check_eq({tag, "_nwr"}, got_q.size(), 1);
        if (got_q.size() > 0) check_eq({tag, "_word"}, got_q.pop_front(), exp);
        check_eq({tag, "_hold"}, fifo_data, exp);
        check_eq({tag, "_busy"}, busy, 1'b0);
        got_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       pe, po, pb, st;
        logic [9:0] exp;

        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_wrreq", fifo_wrreq, 1'b0);
        check_eq("rst_data", fifo_data, 10'h0);
        check_eq("rst_overrun", overrun, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        aclr = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_one("t1_a5", 10'h0A5);
        check_eq("t1_overrun", overrun, 1'b0);

        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_one("t2_bad_par", 10'h203);
        send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_one("t2_good_par", 10'h003);

        for (int k = 0; k < 24; k++) begin
            d   = 8'($urandom);
            pe  = 1'($urandom);
            po  = 1'($urandom);
            pb  = 1'($urandom);
            st  = ($urandom_range(0, 5) != 0);
            exp = model_word(d, pe, po, pb, st);
            send_frame(d, pe, po, pb, st, 1'b1);
            expect_one($sformatf("rnd%0d", k), exp);
        end

        // Break: line held low through and long after the stop bit.
        parity_en = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 9; i++) send_bit(1'b0);
        for (int i = 0; i < 40; i++) send_bit(1'b0);
        check_eq("brk_busy", busy, 1'b0);
        check_eq("brk_nwr_low", got_q.size(), 1);
        send_bit(1'b1);
        send_bit(1'b1);
        expect_one("brk", 10'h100);

        // False start: 4-tick glitch.
        rxd = 1'b0;
        wait_ticks(4);
        #1;
        rxd = 1'b1;
        wait_ticks(2);
        #1;
        check_eq("glitch_busy_hi", busy, 1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        check_eq("glitch_busy_lo", busy, 1'b0);
        check_eq("glitch_nwr", got_q.size(), 0);

        // Overrun on a full FIFO, then clear.
        exp = fifo_data;
        fifo_full = 1'b1;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("ovr_nwr", got_q.size(), 0);
        check_eq("ovr_set", overrun, 1'b1);
        check_eq("ovr_data_held", fifo_data, exp);
        clr_overrun = 1'b1;
        @(posedge clock);
        #1;
        clr_overrun = 1'b0;
        check_eq("ovr_clr", overrun, 1'b0);

        // Clear held across the set clock: set must win for that clock.
        seen_set_clr = 1'b0;
        clr_overrun = 1'b1;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        clr_overrun = 1'b0;
        check_eq("ovr_set_vs_clr", seen_set_clr, 1'b1);
        check_eq("ovr_after_clr", overrun, 1'b0);

        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("ovr_set2", overrun, 1'b1);
        fifo_full = 1'b0;
        got_q.delete();

        // Reset mid-DATA aborts the frame.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        aclr = 1'b1;
        rxd  = 1'b1;
        #1;
        check_eq("aclr_busy", busy, 1'b0);
        check_eq("aclr_data", fifo_data, 10'h0);
        check_eq("aclr_overrun", overrun, 1'b0);
        check_eq("aclr_wrreq", fifo_wrreq, 1'b0);
        @(posedge clock);
        #1;
        aclr = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        check_eq("aclr_nwr", got_q.size(), 0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_one("aclr_3c", 10'h03C);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
